// File: rtl/secuenciador_rotacion_pkg.sv
// Shared encodings for the rotation sequencer: FSM state codes and rotate directions.
package secuenciador_rotacion_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ROTA  = 2'd1;
    localparam logic [1:0] ST_HECHO = 2'd2;

    localparam logic DIR_IZQ = 1'b0;  // toward LSB
    localparam logic DIR_DER = 1'b1;  // toward MSB

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        ROTA  = ST_ROTA,
        HECHO = ST_HECHO
    } estado_t;

endpackage

// File: rtl/secuenciador_rotacion_paso.sv
// One rotate step: by 1 or 2 positions in either direction (purely combinational).
module paso_rotacion
    import secuenciador_rotacion_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] d,
    input  logic             dir,
    input  logic             dos,
    output logic [WIDTH-1:0] q
);

    always_comb begin
        q = d;
        case ({dir, dos})
            {DIR_IZQ, 1'b1}: q = {d[1:0], d[WIDTH-1:2]};
            {DIR_IZQ, 1'b0}: q = {d[0], d[WIDTH-1:1]};
            {DIR_DER, 1'b1}: q = {d[WIDTH-3:0], d[WIDTH-1:WIDTH-2]};
            {DIR_DER, 1'b0}: q = {d[WIDTH-2:0], d[WIDTH-1]};
            default:         q = d;
        endcase
    end

endmodule

// File: rtl/secuenciador_rotacion.sv
// Multi-cycle variable rotator: one shared by-1/by-2 step per cycle, inicio/ocupado
// job handshake, result held in HECHO until salida_ack.
module secuenciador_rotacion
    import secuenciador_rotacion_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inicio,
    input  logic             direccion,
    input  logic [CNT_W-1:0] cantidad,
    input  logic [WIDTH-1:0] entrada,
    output logic             ocupado,
    output logic             salida_valida,
    input  logic             salida_ack,
    output logic [WIDTH-1:0] salida
);

    estado_t          state, state_next;
    logic [WIDTH-1:0] d, d_next, salida_next, paso_q;
    logic [CNT_W-1:0] rem, rem_next, cant_m;
    logic             dir, dir_next;
    logic             dos, acepta;

    // cantidad < 2*WIDTH whenever CNT_W == clog2(WIDTH), so one subtraction reduces mod WIDTH
    assign cant_m = (32'(cantidad) >= WIDTH) ? CNT_W'(32'(cantidad) - WIDTH) : cantidad;
    assign dos    = (rem >= CNT_W'(2));
    assign acepta = inicio && ((state == IDLE) || (state == HECHO && salida_ack));

    paso_rotacion #(.WIDTH(WIDTH)) u_paso (
        .d  (d),
        .dir(dir),
        .dos(dos),
        .q  (paso_q)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            d      <= '0;
            rem    <= '0;
            dir    <= DIR_IZQ;
            salida <= '0;
        end else begin
            state  <= state_next;
            d      <= d_next;
            rem    <= rem_next;
            dir    <= dir_next;
            salida <= salida_next;
        end
    end

    always_comb begin
        state_next  = state;
        d_next      = d;
        rem_next    = rem;
        dir_next    = dir;
        salida_next = salida;
        if (acepta) begin
            d_next   = entrada;
            dir_next = direccion;
            rem_next = cant_m;
            if (cant_m == '0) begin
                state_next  = HECHO;
                salida_next = entrada;
            end else begin
                state_next  = ROTA;
            end
        end else begin
            case (state)
                ROTA: begin
                    d_next   = paso_q;
                    rem_next = dos ? rem - CNT_W'(2) : rem - CNT_W'(1);
                    if (rem_next == '0) begin
                        state_next  = HECHO;
                        salida_next = paso_q;
                    end
                end
                HECHO:   if (salida_ack) state_next = IDLE;
                IDLE:    state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    assign ocupado       = (state != IDLE);
    assign salida_valida = (state == HECHO);

endmodule

// File: tb/tb_secuenciador_rotacion.sv
// Directed bench for secuenciador_rotacion: hand-computed vectors plus a bit-serial reference model.
module tb_secuenciador_rotacion;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       inicio = 1'b0;
    logic       direccion = 1'b0;
    logic [2:0] cantidad = '0;
    logic [7:0] entrada = '0;
    logic       salida_ack = 1'b0;
    logic       ocupado, salida_valida;
    logic [7:0] salida;

    int         n_chk = 0;
    int         n_ok  = 0;
    logic [7:0] exp_q = '0;

    secuenciador_rotacion #(.WIDTH(8), .CNT_W(3)) dut (
        .clk          (clk),
        .reset        (reset),
        .inicio       (inicio),
        .direccion    (direccion),
        .cantidad     (cantidad),
        .entrada      (entrada),
        .ocupado      (ocupado),
        .salida_valida(salida_valida),
        .salida_ack   (salida_ack),
        .salida       (salida)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_ok++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // one position per iteration, independent of the by-2 stepping in the design
    function automatic logic [7:0] rot_ref(input logic [7:0] v, input logic dr, input int n);
        logic [7:0] r;
        r = v;
        for (int i = 0; i < n; i++) r = dr ? {r[6:0], r[7]} : {r[0], r[7:1]};
        return r;
    endfunction

    // result must match the held expectation on every cycle it is valid
    always @(negedge clk) if (!reset && salida_valida) chk("mon_salida", salida, exp_q);

    // called at a negedge; returns at the negedge where salida_valida is first seen
    task automatic run_job(input string tag, input logic [7:0] e, input logic dr, input logic [2:0] c,
                           input logic [7:0] exp, input int exp_lat, input bit b2b, input bit poke);
        int lat;
        lat = 0;
        entrada = e; direccion = dr; cantidad = c; inicio = 1'b1;
        if (b2b) salida_ack = 1'b1;
        forever begin
            @(posedge clk);
            lat++;
            if (lat == 1) exp_q = exp;
            @(negedge clk);
            inicio = 1'b0; salida_ack = 1'b0;
            if (b2b && lat == 1) begin
                chk({tag, "_b2b_ocupado"}, ocupado, 1);
                chk({tag, "_b2b_valid"}, salida_valida, 0);
            end
            if (poke && lat == 2) begin
                inicio = 1'b1; entrada = 8'hFF; direccion = 1'b1; cantidad = 3'd0;
            end
            if (salida_valida || lat > 20) break;
        end
        chk({tag, "_lat"}, lat, exp_lat);
        chk({tag, "_salida"}, salida, exp);
        chk({tag, "_ref"}, salida, rot_ref(e, dr, int'(c)));
    endtask

    task automatic ack();
        salida_ack = 1'b1;
        @(posedge clk);
        @(negedge clk);
        salida_ack = 1'b0;
        chk("ack_valid", salida_valida, 0);
        chk("ack_ocupado", ocupado, 0);
    endtask

    initial begin
        @(negedge clk); @(negedge clk);
        chk("rst_ocupado", ocupado, 0);
        chk("rst_valid", salida_valida, 0);
        chk("rst_salida", salida, 0);
        reset = 1'b0;
        @(negedge clk);

        // T2
        run_job("t2", 8'hB4, 1'b0, 3'd2, 8'h2D, 2, 0, 0);
        ack();
        chk("t2_hold_idle", salida, 8'h2D);

        // T1: asynchronous reset mid-ROTA
        entrada = 8'hB4; direccion = 1'b0; cantidad = 3'd7; inicio = 1'b1;
        @(posedge clk);
        @(negedge clk);
        inicio = 1'b0;
        chk("t1_rota_ocupado", ocupado, 1);
        chk("t1_rota_hold", salida, 8'h2D);
        #2 reset = 1'b1;
        #1;
        chk("t1_ocupado", ocupado, 0);
        chk("t1_valid", salida_valida, 0);
        chk("t1_salida", salida, 0);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("t1_idle", ocupado, 0);

        // T3
        run_job("t3a", 8'hB4, 1'b0, 3'd3, 8'h96, 3, 0, 0);
        ack();
        run_job("t3b", 8'hB4, 1'b1, 3'd3, 8'hA5, 3, 0, 0);

        // T5: no ack for 10 cycles, result held
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("t5_valid", salida_valida, 1);
            chk("t5_salida", salida, 8'hA5);
        end

        // T6: ack and new start in the same cycle
        run_job("t6", 8'h0F, 1'b1, 3'd4, 8'hF0, 3, 1, 0);
        ack();

        // T4 (with an ignored inicio pulse during ROTA)
        run_job("t4a", 8'h81, 1'b0, 3'd7, 8'h03, 5, 0, 1);
        ack();
        run_job("t4b", 8'h81, 1'b0, 3'd0, 8'h81, 1, 0, 0);
        ack();
        run_job("dir1_6", 8'hB4, 1'b1, 3'd6, 8'h2D, 4, 0, 0);
        ack();

        // ack outside HECHO is ignored
        salida_ack = 1'b1;
        @(posedge clk);
        @(negedge clk);
        salida_ack = 1'b0;
        chk("idle_ack_ocupado", ocupado, 0);
        chk("idle_ack_salida", salida, 8'h2D);

        $display("%0d/%0d checks passed", n_ok, n_chk);
        $finish;
    end

endmodule
